// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared opcode, condition-code, FSM-state and flag-index definitions
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_XOR    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GE     = 3'b100;
  localparam logic [2:0] CC_LE     = 3'b101;
  localparam logic [2:0] CC_OVF    = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_EXEC   = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Field order matches the FLAG_* indices so the struct can be used as a plain 3-bit vector.
  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - evaluates a 3-bit branch condition code against the {Z,V,N} flags
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NE:     taken = !z;
      CC_EQ:     taken = z;
      CC_GT:     taken = !z && !n;
      CC_LT:     taken = n;
      CC_GE:     taken = z || !n;
      CC_LE:     taken = n || z;
      CC_OVF:    taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/IR/flag holder that fetches over a ready handshake and sequences FETCH/EXEC/HALT
module fetch_sequencer
  import wisc_pkg::*;
#(
  parameter int            AW       = 16,
  parameter int            IW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_re,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rdy,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_vld,
  input  logic          branch,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic          set_zero,
  input  logic          set_over,
  input  logic          alu_zr,
  input  logic          alu_ov,
  input  logic          alu_neg,
  input  logic [AW-1:0] ret_addr,
  output logic [AW-1:0] link_addr,
  input  logic          stall,
  output logic [2:0]    flags,
  output logic          halted
);

  logic [1:0]    state;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;
  flags_t        flg;

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] br_off;
  logic [AW-1:0] call_off;
  logic [AW-1:0] pc_next;
  logic          taken;

  assign pc_inc   = pc + AW'(1);
  assign br_off   = {{(AW-9){ir[8]}}, ir[8:0]};
  assign call_off = {{(AW-12){ir[11]}}, ir[11:0]};

  // Condition is judged on the flags held before this instruction writes them.
  branch_cond u_branch_cond (
    .cond  (ir[11:9]),
    .flags (flg),
    .taken (taken)
  );

  always_comb begin
    pc_next = pc_inc;
    if (halt) begin
      pc_next = pc;
    end else if (ret) begin
      pc_next = ret_addr;
    end else if (call) begin
      pc_next = pc_inc + call_off;
    end else if (branch && taken) begin
      pc_next = pc_inc + br_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      flg   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_rdy) begin
            ir    <= imem_data;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            if (set_zero) begin
              flg.z <= alu_zr;
            end
            if (set_over) begin
              flg.v <= alu_ov;
              flg.n <= alu_neg;
            end
            pc    <= pc_next;
            state <= halt ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  // Handshake outputs are forced quiet during reset so a stale FETCH never issues a request.
  assign imem_re   = !rst && (state == ST_FETCH);
  assign instr_vld = !rst && (state == ST_EXEC);
  assign halted    = (state == ST_HALT);
  assign imem_addr = pc;
  assign instr     = ir;
  assign link_addr = pc_inc;
  assign flags     = flg;

endmodule
